// File: rtl/tc_sram_banked_pkg.sv
// Shared helpers and types for the banked SRAM: width derivation, address split
// into bank/row, and the per-port response tag carried through the latency pipeline.
package tc_sram_banked_pkg;

    // Upper bound on bank-select bits carried in a response tag (up to 256 banks).
    localparam int unsigned MaxBankSelW = 8;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [MaxBankSelW-1:0] bank;
    } resp_tag_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned be_width(input int unsigned data_w, input int unsigned byte_w);
        return (data_w + byte_w - 1) / byte_w;
    endfunction

    // Word-interleaved mapping: low address bits pick the bank, the rest pick the row.
    function automatic int unsigned bank_sel(input int unsigned addr, input int unsigned sel_w);
        return addr & ((32'd1 << sel_w) - 32'd1);
    endfunction

    function automatic int unsigned row(input int unsigned addr, input int unsigned sel_w);
        return addr >> sel_w;
    endfunction

endpackage

// File: rtl/tc_sram_bank_arb.sv
// Per-bank round-robin arbiter. Combinational grant; the priority pointer moves
// past the winner only in cycles where this bank grants.
module tc_sram_bank_arb
    import tc_sram_banked_pkg::*;
#(
    parameter int unsigned NumPorts = 2,
    localparam int unsigned IdxW    = clog2_min1(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] req,
    output logic [NumPorts-1:0] gnt,
    output logic [IdxW-1:0]     idx
);

    logic [IdxW-1:0] rr_ptr;
    logic            found;
    int unsigned     cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NumPorts; off++) begin
            cand = 32'(rr_ptr) + off;
            if (cand >= NumPorts) cand = cand - NumPorts;
            if (!found && req[IdxW'(cand)]) begin
                found             = 1'b1;
                gnt[IdxW'(cand)]  = 1'b1;
                idx               = IdxW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (|req) begin
            rr_ptr <= (32'(idx) == NumPorts - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/tc_sram_impl.sv
// Behavioural single-port SRAM macro model: byte-enabled writes, fixed read latency.
// Read data holds its last value between reads; callers qualify it with their own valid.
module tc_sram_impl
    import tc_sram_banked_pkg::*;
#(
    parameter int unsigned NumWords     = 1024,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned ByteWidth    = 8,
    parameter int unsigned NumPorts     = 1,
    parameter int unsigned Latency      = 1,
    parameter              SimInit      = "none",
    parameter int unsigned ImplInWidth  = 1,
    parameter int unsigned ImplOutWidth = 1,
    parameter logic [ImplOutWidth-1:0] ImplOutSim = '0,
    localparam int unsigned AddrWidth   = clog2_min1(NumWords),
    localparam int unsigned BeWidth     = be_width(DataWidth, ByteWidth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ImplInWidth-1:0]  impl_i,
    output logic [ImplOutWidth-1:0] impl_o,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [AddrWidth-1:0]    addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    output logic [DataWidth-1:0]    rdata_o
);

    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] rdata_q [Latency];
    logic [DataWidth-1:0] wmask;

    assign impl_o = ImplOutSim;

    // NOTE: every variable written in always_comb gets a default on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            wmask[i] = be_i[i / int'(ByteWidth)];
        end
    end

    // NOTE: the storage array has no reset; clearing a RAM is not possible in one
    // cycle in silicon, and its contents must survive a logic reset anyway.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem[addr_i] <= (mem[addr_i] & ~wmask) | (wdata_i & wmask);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the pre-edge value of its predecessor, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(Latency); s++) rdata_q[s] <= '0;
        end else begin
            if (req_i && !we_i) rdata_q[0] <= mem[addr_i];
            for (int s = 1; s < int'(Latency); s++) rdata_q[s] <= rdata_q[s-1];
        end
    end

    assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/tc_sram_banked.sv
// Multi-port word-interleaved banked SRAM: per-bank round-robin arbitration in front
// of single-port macros, with per-port tag pipelines that steer and mask read data.
module tc_sram_banked
    import tc_sram_banked_pkg::*;
#(
    parameter int unsigned NumWords     = 1024,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned ByteWidth    = 8,
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned Latency      = 1,
    parameter              SimInit      = "none",
    parameter int unsigned ImplInWidth  = 1,
    parameter int unsigned ImplOutWidth = 1,
    parameter logic [ImplOutWidth-1:0] ImplOutSim = '0,
    localparam int unsigned AddrWidth   = $clog2(NumWords),
    localparam int unsigned BeWidth     = be_width(DataWidth, ByteWidth),
    localparam int unsigned BankSelW    = $clog2(NumBanks)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [ImplInWidth-1:0]              impl_i,
    output logic [ImplOutWidth-1:0]             impl_o,
    input  logic [NumPorts-1:0]                 req_i,
    output logic [NumPorts-1:0]                 gnt_o,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

    localparam int unsigned BankIdxW = clog2_min1(NumBanks);
    localparam int unsigned RowW     = clog2_min1(NumWords / NumBanks);
    localparam int unsigned PortIdxW = clog2_min1(NumPorts);

    if (Latency < 1) begin : g_latency_check
        $fatal(1, "tc_sram_banked: Latency must be at least 1");
    end

    logic [NumPorts-1:0][BankIdxW-1:0] port_bank;
    logic [NumPorts-1:0][RowW-1:0]     port_row;
    logic [NumPorts-1:0]               arb_req [NumBanks];
    logic [NumPorts-1:0]               arb_gnt [NumBanks];
    logic [PortIdxW-1:0]               arb_idx [NumBanks];
    logic [DataWidth-1:0]              bank_rdata [NumBanks];
    logic [ImplOutWidth-1:0]           bank_impl_o [NumBanks];
    resp_tag_t                         tag_q [NumPorts][Latency];
    resp_tag_t                         resp;

    assign impl_o = ImplOutSim;

    // Requests are masked during reset so no grant is raised and no pointer moves.
    always_comb begin
        port_bank = '0;
        port_row  = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            port_bank[p] = BankIdxW'(bank_sel(32'(addr_i[p]), BankSelW));
            port_row[p]  = RowW'(row(32'(addr_i[p]), BankSelW));
        end
        for (int b = 0; b < int'(NumBanks); b++) begin
            arb_req[b] = '0;
            for (int p = 0; p < int'(NumPorts); p++) begin
                arb_req[b][p] = req_i[p] & ~rst_i & (port_bank[p] == BankIdxW'(b));
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < int'(NumBanks); b++) gnt_o = gnt_o | arb_gnt[b];
    end

    for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
        tc_sram_bank_arb #(
            .NumPorts (NumPorts)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req   (arb_req[b]),
            .gnt   (arb_gnt[b]),
            .idx   (arb_idx[b])
        );

        tc_sram_impl #(
            .NumWords     (NumWords / NumBanks),
            .DataWidth    (DataWidth),
            .ByteWidth    (ByteWidth),
            .NumPorts     (1),
            .Latency      (Latency),
            .SimInit      (SimInit),
            .ImplInWidth  (ImplInWidth),
            .ImplOutWidth (ImplOutWidth),
            .ImplOutSim   (ImplOutSim)
        ) u_sram (
            .clk_i   (clk_i),
            .rst_ni  (1'b1),
            .impl_i  (impl_i),
            .impl_o  (bank_impl_o[b]),
            .req_i   (|arb_gnt[b]),
            .we_i    (we_i[arb_idx[b]]),
            .addr_i  (port_row[arb_idx[b]]),
            .wdata_i (wdata_i[arb_idx[b]]),
            .be_i    (be_i[arb_idx[b]]),
            .rdata_o (bank_rdata[b])
        );
    end

    // The tag travels alongside the bank's own read pipeline, so at the last stage
    // the bank's rdata belongs to exactly this port's grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < int'(NumPorts); p++)
                for (int s = 0; s < int'(Latency); s++) tag_q[p][s] <= '0;
        end else begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                tag_q[p][0] <= '{valid: gnt_o[p], we: we_i[p], bank: MaxBankSelW'(port_bank[p])};
                for (int s = 1; s < int'(Latency); s++) tag_q[p][s] <= tag_q[p][s-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        resp     = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            resp        = tag_q[p][Latency-1];
            rvalid_o[p] = resp.valid;
            if (resp.valid && !resp.we) rdata_o[p] = bank_rdata[resp.bank[BankIdxW-1:0]];
        end
    end

endmodule
